// File: rtl/button_repeat_ctrl.sv
// button_repeat_ctrl: debounced up/down keys to inc/dec strobes with hold auto-repeat and acceleration
module button_repeat_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int FAST_AFTER      = 10,
    parameter int STEP_SLOW       = 1,
    parameter int STEP_FAST       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button1,
    input  logic       button2,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic [3:0] step,
    output logic       held
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(FAST_AFTER + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_deb;
    logic [DW-1:0] r_dcnt [2];
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_rcnt;
    logic          r_dir;
    logic          r_inc;
    logic          r_dec;
    logic [3:0]    r_step;

    state_t        w_state;
    logic [TW-1:0] w_timer;
    logic [TW-1:0] w_tmr_inc;
    logic [RW-1:0] w_rcnt;
    logic          w_dir;
    logic          w_fire;
    logic [3:0]    w_step;
    logic [1:0]    w_pr;
    logic          w_act;
    logic          w_oth;

    // bit 0 is the up key, bit 1 the down key; levels are active-low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1      <= 2'b11;
            r_s2      <= 2'b11;
            r_deb     <= 2'b11;
            r_dcnt[0] <= '0;
            r_dcnt[1] <= '0;
        end else begin
            r_s1 <= {button2, button1};
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                r_dcnt[i] <= (r_s2[i] == r_deb[i] || r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : r_dcnt[i] + 1'b1;
                if (r_s2[i] != r_deb[i] && r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1))
                    r_deb[i] <= r_s2[i];
            end
        end
    end

    assign w_pr      = ~r_deb;
    assign w_act     = r_dir ? w_pr[1] : w_pr[0];
    assign w_oth     = r_dir ? w_pr[0] : w_pr[1];
    assign w_tmr_inc = r_timer + 1'b1;

    always_comb begin
        w_state = r_state;
        w_timer = r_timer;
        w_rcnt  = r_rcnt;
        w_dir   = r_dir;
        w_fire  = 1'b0;
        w_step  = 4'(STEP_SLOW);
        case (r_state)
            IDLE: begin
                if (&w_pr) begin
                    w_state = LOCK;
                end else if (|w_pr) begin
                    w_state = HOLD;
                    w_dir   = w_pr[1];
                    w_timer = '0;
                    w_fire  = 1'b1;
                end
            end
            HOLD, REPEAT: begin
                // a release seen together with timer expiry must not strobe
                if (!w_act || w_oth) begin
                    w_state = w_act ? LOCK : IDLE;
                    w_timer = '0;
                    w_rcnt  = '0;
                end else if (r_state == HOLD) begin
                    if (w_tmr_inc == TW'(HOLD_CYCLES)) begin
                        w_state = REPEAT;
                        w_timer = '0;
                        w_rcnt  = RW'(1);
                        w_fire  = 1'b1;
                    end else begin
                        w_timer = w_tmr_inc;
                    end
                end else if (w_tmr_inc == TW'(REPEAT_CYCLES)) begin
                    w_timer = '0;
                    w_fire  = 1'b1;
                    w_step  = (r_rcnt >= RW'(FAST_AFTER)) ? 4'(STEP_FAST) : 4'(STEP_SLOW);
                    w_rcnt  = (r_rcnt >= RW'(FAST_AFTER)) ? r_rcnt : r_rcnt + 1'b1;
                end else begin
                    w_timer = w_tmr_inc;
                end
            end
            LOCK: w_state = (&r_deb) ? IDLE : LOCK;
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_rcnt  <= '0;
            r_dir   <= 1'b0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_step  <= 4'(STEP_SLOW);
        end else begin
            r_state <= w_state;
            r_timer <= w_timer;
            r_rcnt  <= w_rcnt;
            r_dir   <= w_dir;
            r_inc   <= w_fire & ~w_dir;
            r_dec   <= w_fire & w_dir;
            r_step  <= w_step;
        end
    end

    assign inc_pulse = r_inc;
    assign dec_pulse = r_dec;
    assign step      = r_step;
    assign held      = (r_state == HOLD) || (r_state == REPEAT);
endmodule

// File: doc/button_repeat_ctrl.md
# button_repeat_ctrl

Input front-end for the oven setpoint logic: conditions the two raw active-low pushbuttons (button1 = up, button2 = down) into clean single-cycle increment/decrement strobes with press-and-hold auto-repeat and acceleration. It sits between the board KEY pins and the time/temperature setpoint registers. Those registers consume `inc_pulse` / `dec_pulse` / `step` on the system clock instead of sampling raw buttons on a divided clock.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- `HOLD_CYCLES`, default 25000000: cycles from the initial press strobe to the first auto-repeat strobe (0.5 s).
- `REPEAT_CYCLES`, default 5000000: cycles between auto-repeat strobes (0.1 s).
- `FAST_AFTER`, default 10: number of auto-repeat strobes at slow step before switching to fast step.
- `STEP_SLOW`, default 1: step value for the press strobe and early repeat strobes.
- `STEP_FAST`, default 5: step value after acceleration.

Ports:
- `clk` — input, 1 bit — system clock, 50 MHz.
- `rst_n` — input, 1 bit — reset; one clock, synchronous, active-low.
- `button1` — input, 1 bit — raw up key; active-low, asynchronous to `clk`.
- `button2` — input, 1 bit — raw down key; active-low, asynchronous to `clk`.
- `inc_pulse` — output, 1 bit — one-cycle increment strobe.
- `dec_pulse` — output, 1 bit — one-cycle decrement strobe.
- `step` — output, 4 bits — step amount; valid in any cycle where `inc_pulse` or `dec_pulse` is high.
- `held` — output, 1 bit — high while in HOLD or REPEAT; drives the UI "adjusting" LED.

## Operation

- **Synchronizer:** each button passes through a 2-flop synchronizer. Both flops reset to 1 (released).
- **Debounce:** one counter per button, sized by `$clog2(DEBOUNCE_CYCLES+1)`.
  - Counter increments each cycle the synchronized level differs from the debounced level.
  - Counter clears in any cycle the levels match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized level and the counter clears.
  - Debounced levels reset to 1.
- **State machine** (one timer counter sized for `HOLD_CYCLES`, one repeat counter sized for `FAST_AFTER`):
  - **IDLE**
    - Debounced press of exactly one button → emit a strobe for that button with `step=STEP_SLOW`, clear the timer, go to HOLD. Record the direction.
    - Both buttons debounced-pressed in the same cycle → go to LOCK, no strobe.
  - **HOLD**
    - Timer increments each cycle.
    - Timer reaches `HOLD_CYCLES` → strobe (`STEP_SLOW`), clear timer, repeat count=1, go to REPEAT.
  - **REPEAT**
    - Timer increments each cycle.
    - Timer reaches `REPEAT_CYCLES` → strobe and clear timer.
    - The strobe uses `step=STEP_FAST` when repeat count ≥ `FAST_AFTER`, else `STEP_SLOW`.
    - Repeat count saturates at `FAST_AFTER`.
  - **HOLD / REPEAT, release:** debounced release of the active button → IDLE, no strobe, counters clear.
  - **HOLD / REPEAT, other button:** debounced press of the other button → LOCK, no strobe.
  - **LOCK:** no strobes. Return to IDLE only when both debounced levels are 1. This state exists so the setpoint never sees an up and a down in the same press.
- **Output exclusivity:** `inc_pulse` and `dec_pulse` are never high in the same cycle.
- **`step` default:** `step` holds `STEP_SLOW` whenever no strobe is active.

## Timing

- **Reset values:**
  - `inc_pulse=0`, `dec_pulse=0`, `held=0`, `step=STEP_SLOW`.
  - State IDLE; all counters 0.
- **Mid-operation reset:** `rst_n` low mid-press → the next cycle returns to the reset values. A still-held button is then re-debounced and produces a fresh press strobe.
- **Press latency:** let edge k be the first `clk` edge that samples a raw low.
  - The debounced level changes at edge k+1+`DEBOUNCE_CYCLES`.
  - The strobe is registered at edge k+2+`DEBOUNCE_CYCLES` and is high for exactly one cycle.
- **Bounce rejection:** any raw glitch shorter than `DEBOUNCE_CYCLES` cycles (after sync) produces no strobe and no state change.
- **Repeat timing:**
  - First repeat strobe occurs `HOLD_CYCLES` cycles after the press strobe.
  - Subsequent repeat strobes are spaced exactly `REPEAT_CYCLES` cycles apart.
- **Release:** the release is debounced with the same latency as a press. No strobe is emitted on release, even if the timer expires in the same cycle the debounced release is seen; release wins.
- **`held` timing:** `held` rises in the cycle after the press strobe and falls in the cycle after leaving HOLD or REPEAT.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=20`, `REPEAT_CYCLES=5`, `FAST_AFTER=3`, `STEP_SLOW=1`, `STEP_FAST=5`.

1. **Reset:** hold `rst_n=0` for 3 cycles with `button1=0` → all outputs at reset values. After release, one `inc_pulse` appears 6 cycles after the first sampling edge.
2. **Bounce:** toggle `button1` 1→0→1→0 with 2-cycle segments, then hold low → exactly one `inc_pulse` with `step=1`, counted from the start of the final stable low.
3. **Hold with acceleration:** hold `button2` low for 80 cycles → `dec_pulse` at press, +20, +25, +30, +35, +40, ….
   - The first three repeat strobes have `step=1`; later ones have `step=5`.
   - `held=1` throughout.
4. **Short press:** press `button1` for 10 cycles, then release → exactly one `inc_pulse`, no repeat. `held` returns to 0 and the state is IDLE.
5. **Second button during hold:** hold `button1`, then press `button2` at cycle 12 of HOLD → no further strobes of either kind.
   - Releasing only `button1` still gives no strobes.
   - Releasing both, then pressing `button2` → one `dec_pulse`.
6. **Simultaneous press:** press both buttons on the same edge → zero strobes; the block stays in LOCK until both are released.
